// File: rtl/sw_alloc_ctrl.sv
// rtl/sw_alloc_ctrl.sv - wormhole switch allocator with round-robin grant, credit pacing and crossbar selects
module sw_alloc_ctrl #(
  parameter int NPORT    = 5,
  parameter int PIDX_W   = 3,
  parameter int CRED_MAX = 4,
  parameter int CRED_W   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT*PIDX_W-1:0] req_out,
  input  logic [NPORT*2-1:0]      flit_type,
  input  logic [NPORT-1:0]        pop,
  input  logic [NPORT-1:0]        credit_ret,
  output logic [NPORT-1:0]        st_ack,
  output logic [NPORT-1:0]        st_go,
  output logic [NPORT*PIDX_W-1:0] xbar_sel,
  output logic [NPORT-1:0]        out_valid,
  output logic [NPORT*CRED_W-1:0] credits
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACTIVE} state_t;

  localparam logic [PIDX_W-1:0] SEL_IDLE  = '1;
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CRED_MAX);
  localparam logic [1:0]        FT_HEAD   = 2'b11;
  localparam logic [1:0]        FT_TAIL   = 2'b10;

  state_t            state_q [NPORT];
  state_t            state_d [NPORT];
  logic [PIDX_W-1:0] owner_q [NPORT];
  logic [PIDX_W-1:0] owner_d [NPORT];
  logic [PIDX_W-1:0] rr_q    [NPORT];
  logic [PIDX_W-1:0] rr_d    [NPORT];
  logic [CRED_W-1:0] cred_q  [NPORT];
  logic [CRED_W-1:0] cred_d  [NPORT];

  logic [NPORT-1:0]  busy;
  logic [NPORT-1:0]  qpop;
  logic              found;
  int                idx;

  // Output-side decode: an input is busy while any output holds it in GRANT or ACTIVE.
  always_comb begin
    busy      = '0;
    qpop      = '0;
    st_ack    = '0;
    st_go     = '0;
    out_valid = '0;
    xbar_sel  = {NPORT{SEL_IDLE}};
    credits   = '0;
    for (int o = 0; o < NPORT; o++) begin
      credits[o*CRED_W +: CRED_W] = cred_q[o];
      if (state_q[o] != S_IDLE) begin
        busy[owner_q[o]]             = 1'b1;
        xbar_sel[o*PIDX_W +: PIDX_W] = owner_q[o];
      end
      if (state_q[o] == S_GRANT) begin
        st_ack[owner_q[o]] = 1'b1;
      end
      if (state_q[o] == S_ACTIVE && cred_q[o] != '0) begin
        st_go[owner_q[o]] = 1'b1;
        if (pop[owner_q[o]]) begin
          out_valid[o] = 1'b1;
          qpop[o]      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < NPORT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      cred_d[o]  = cred_q[o];
      found      = 1'b0;

      case (state_q[o])
        S_IDLE: begin
          for (int k = 0; k < NPORT; k++) begin
            idx = (int'(rr_q[o]) + k) % NPORT;
            if (!found && req[idx] && !busy[idx] &&
                req_out[idx*PIDX_W +: PIDX_W] == PIDX_W'(o) &&
                flit_type[idx*2 +: 2] == FT_HEAD) begin
              found      = 1'b1;
              owner_d[o] = PIDX_W'(idx);
              state_d[o] = S_GRANT;
            end
          end
        end
        S_GRANT: state_d[o] = S_ACTIVE;
        S_ACTIVE: begin
          if (qpop[o] && flit_type[int'(owner_q[o])*2 +: 2] == FT_TAIL) begin
            state_d[o] = S_IDLE;
            rr_d[o]    = PIDX_W'((int'(owner_q[o]) + 1) % NPORT);
          end
        end
        default: state_d[o] = S_IDLE;
      endcase

      // A pop and a return in the same cycle cancel; a return at full is dropped.
      case ({qpop[o], credit_ret[o]})
        2'b10:   cred_d[o] = cred_q[o] - CRED_W'(1);
        2'b01:   if (cred_q[o] != CRED_FULL) cred_d[o] = cred_q[o] + CRED_W'(1);
        default: cred_d[o] = cred_q[o];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= S_IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
        cred_q[o]  <= CRED_FULL;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        cred_q[o]  <= cred_d[o];
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc_ctrl.sv
// tb/tb_sw_alloc_ctrl.sv - scoreboard bench for sw_alloc_ctrl: grants, wormhole release, credits, reset
module tb_sw_alloc_ctrl;

  localparam logic [14:0] XB_IDLE  = 15'h7fff;
  localparam logic [14:0] CRED_ALL = {5{3'd4}};

  logic        clk;
  logic        reset;
  logic [4:0]  req;
  logic [14:0] req_out;
  logic [9:0]  flit_type;
  logic [4:0]  pop;
  logic [4:0]  credit_ret;
  logic [4:0]  st_ack;
  logic [4:0]  st_go;
  logic [14:0] xbar_sel;
  logic [4:0]  out_valid;
  logic [14:0] credits;

  sw_alloc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_out    (req_out),
    .flit_type  (flit_type),
    .pop        (pop),
    .credit_ret (credit_ret),
    .st_ack     (st_ack),
    .st_go      (st_go),
    .xbar_sel   (xbar_sel),
    .out_valid  (out_valid),
    .credits    (credits)
  );

  typedef struct {
    logic [4:0]  ack;
    logic [14:0] xbar;
  } ack_t;

  typedef struct {
    int         o;
    logic [2:0] cred;
  } out_t;

  typedef struct {
    string       name;
    logic [4:0]  ack;
    logic [4:0]  go;
    logic [4:0]  ov;
    logic [14:0] xbar;
    logic [14:0] cred;
  } probe_t;

  ack_t   ack_q[$];
  out_t   out_q[$];
  probe_t probe_q[$];

  ack_t   m_a;
  out_t   m_o;
  probe_t m_p;

  int          n_chk;
  int          n_fail;
  logic        done;
  logic [14:0] exp_xbar;
  logic [14:0] exp_cred;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] xs(input logic [14:0] base, input int o, input int i);
    logic [14:0] r;
    r = base;
    r[o*3 +: 3] = 3'(i);
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: the only process that compares.
  always @(negedge clk) begin
    if (reset) begin
      if (st_ack != 5'd0) begin
        if (ack_q.size() == 0) chk("unexpected_st_ack", 32'(st_ack), 32'd0);
        else begin
          m_a = ack_q.pop_front();
          chk("st_ack", 32'(st_ack), 32'(m_a.ack));
          chk("ack_xbar_sel", 32'(xbar_sel), 32'(m_a.xbar));
        end
      end
      if (out_valid != 5'd0) begin
        if (out_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          m_o = out_q.pop_front();
          chk("out_valid", 32'(out_valid), 32'd1 << m_o.o);
          chk("out_credits", 32'(credits[m_o.o*3 +: 3]), 32'(m_o.cred));
        end
      end
    end
    if (probe_q.size() != 0) begin
      m_p = probe_q.pop_front();
      chk({m_p.name, ".st_ack"},    32'(st_ack),    32'(m_p.ack));
      chk({m_p.name, ".st_go"},     32'(st_go),     32'(m_p.go));
      chk({m_p.name, ".out_valid"}, 32'(out_valid), 32'(m_p.ov));
      chk({m_p.name, ".xbar_sel"},  32'(xbar_sel),  32'(m_p.xbar));
      chk({m_p.name, ".credits"},   32'(credits),   32'(m_p.cred));
    end
    if (done) begin
      chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      chk("out_queue_drained", 32'(out_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic r, input int o, input logic [1:0] ft);
    req[i]             = r;
    req_out[i*3 +: 3]  = 3'(o);
    flit_type[i*2 +: 2] = ft;
  endtask

  task automatic probe(input string n, input logic [4:0] a, input logic [4:0] g, input logic [4:0] v);
    probe_q.push_back('{n, a, g, v, exp_xbar, exp_cred});
  endtask

  task automatic exp_ack(input logic [4:0] a, input logic [14:0] x);
    ack_q.push_back('{a, x});
  endtask

  task automatic exp_out(input int o, input logic [2:0] c);
    out_q.push_back('{o, c});
  endtask

  task automatic do_reset();
    req = '0; req_out = '0; flit_type = '0; pop = '0; credit_ret = '0;
    reset = 1'b0;
    cyc();
    cyc();
    exp_xbar = XB_IDLE;
    exp_cred = CRED_ALL;
    probe("reset", 5'b0, 5'b0, 5'b0);
    cyc();
    reset = 1'b1;
  endtask

  // Grant input i onto output o and move a body+tail packet; credits held at 4 externally.
  task automatic pkt2(input int i, input int o);
    exp_ack(5'(1 << i), xs(XB_IDLE, o, i));
    cyc();
    exp_xbar = xs(XB_IDLE, o, i);
    probe("t2_grant", 5'(1 << i), 5'b0, 5'b0);
    set_in(i, 1'b1, o, 2'b01);
    cyc();
    pop[i] = 1'b1;
    exp_out(o, 3'd4);
    cyc();
    set_in(i, 1'b1, o, 2'b10);
    exp_out(o, 3'd4);
    cyc();
    pop[i] = 1'b0;
    set_in(i, 1'b0, 0, 2'b00);
    exp_xbar = XB_IDLE;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; done = 1'b0;
    reset = 1'b0;
    req = '0; req_out = '0; flit_type = '0; pop = '0; credit_ret = '0;
    exp_xbar = XB_IDLE; exp_cred = CRED_ALL;

    // Test 1: input 2 -> output 4, header then body, body, tail
    do_reset();
    set_in(2, 1'b1, 4, 2'b11);
    probe("t1_idle", 5'b0, 5'b0, 5'b0);
    exp_ack(5'b00100, xs(XB_IDLE, 4, 2));
    cyc();
    exp_xbar = xs(XB_IDLE, 4, 2);
    probe("t1_grant", 5'b00100, 5'b0, 5'b0);
    set_in(2, 1'b1, 4, 2'b01);
    cyc();
    pop[2] = 1'b1;
    exp_out(4, 3'd4);
    probe("t1_go", 5'b0, 5'b00100, 5'b10000);
    cyc();
    exp_cred = xs(exp_cred, 4, 3);
    exp_out(4, 3'd3);
    cyc();
    exp_cred = xs(exp_cred, 4, 2);
    set_in(2, 1'b1, 4, 2'b10);
    exp_out(4, 3'd2);
    probe("t1_tail", 5'b0, 5'b00100, 5'b10000);
    cyc();
    exp_cred = xs(exp_cred, 4, 1);
    pop = '0;
    set_in(2, 1'b0, 0, 2'b00);
    exp_xbar = XB_IDLE;
    probe("t1_released", 5'b0, 5'b0, 5'b0);
    cyc();

    // Test 2: inputs 0,1,3 contend for output 2; round-robin order 0,1,3 then wrap to 4
    do_reset();
    credit_ret[2] = 1'b1;
    set_in(0, 1'b1, 2, 2'b11);
    set_in(1, 1'b1, 2, 2'b11);
    set_in(3, 1'b1, 2, 2'b11);
    pkt2(0, 2);
    pkt2(1, 2);
    pkt2(3, 2);
    set_in(0, 1'b1, 2, 2'b11);
    set_in(4, 1'b1, 2, 2'b11);
    exp_ack(5'b10000, xs(XB_IDLE, 2, 4));
    cyc();
    exp_xbar = xs(XB_IDLE, 2, 4);
    probe("t2_rr_wrap", 5'b10000, 5'b0, 5'b0);
    cyc();
    probe("t2_rr_active", 5'b0, 5'b10000, 5'b0);
    cyc();

    // Test 3: credit exhaustion on output 1, ignored pop, recovery by one credit_ret
    do_reset();
    set_in(0, 1'b1, 1, 2'b11);
    exp_ack(5'b00001, xs(XB_IDLE, 1, 0));
    cyc();
    exp_xbar = xs(XB_IDLE, 1, 0);
    set_in(0, 1'b1, 1, 2'b01);
    cyc();
    pop[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_out(1, 3'(4 - k));
      cyc();
      exp_cred = xs(exp_cred, 1, 3 - k);
    end
    probe("t3_empty_pop", 5'b0, 5'b0, 5'b0);
    cyc();
    pop[0] = 1'b0;
    credit_ret[1] = 1'b1;
    probe("t3_ret", 5'b0, 5'b0, 5'b0);
    cyc();
    credit_ret[1] = 1'b0;
    exp_cred = xs(exp_cred, 1, 1);
    set_in(0, 1'b1, 1, 2'b10);
    pop[0] = 1'b1;
    exp_out(1, 3'd1);
    probe("t3_go_back", 5'b0, 5'b00001, 5'b00010);
    cyc();
    pop = '0;
    set_in(0, 1'b0, 0, 2'b00);
    exp_cred = xs(exp_cred, 1, 0);
    exp_xbar = XB_IDLE;
    probe("t3_released", 5'b0, 5'b0, 5'b0);
    cyc();

    // Test 4: output 0 at credits=2 with simultaneous pop and return, then saturation
    do_reset();
    set_in(3, 1'b1, 0, 2'b11);
    exp_ack(5'b01000, xs(XB_IDLE, 0, 3));
    cyc();
    exp_xbar = xs(XB_IDLE, 0, 3);
    set_in(3, 1'b1, 0, 2'b01);
    cyc();
    pop[3] = 1'b1;
    exp_out(0, 3'd4);
    cyc();
    exp_cred = xs(exp_cred, 0, 3);
    exp_out(0, 3'd3);
    cyc();
    exp_cred = xs(exp_cred, 0, 2);
    credit_ret[0] = 1'b1;
    exp_out(0, 3'd2);
    probe("t4_pop_and_ret", 5'b0, 5'b01000, 5'b00001);
    cyc();
    pop[3] = 1'b0;
    probe("t4_cancel_held", 5'b0, 5'b01000, 5'b0);
    cyc();
    exp_cred = xs(exp_cred, 0, 3);
    cyc();
    exp_cred = xs(exp_cred, 0, 4);
    probe("t4_full_ret", 5'b0, 5'b01000, 5'b0);
    cyc();
    credit_ret[0] = 1'b0;
    set_in(3, 1'b1, 0, 2'b10);
    pop[3] = 1'b1;
    exp_out(0, 3'd4);
    probe("t4_saturated_tail", 5'b0, 5'b01000, 5'b00001);
    cyc();
    pop = '0;
    set_in(3, 1'b0, 0, 2'b00);
    exp_cred = xs(exp_cred, 0, 3);
    exp_xbar = XB_IDLE;
    probe("t4_released", 5'b0, 5'b0, 5'b0);
    cyc();

    // Test 5: parallel grants on outputs 3 and 0, then unroutable requests
    do_reset();
    set_in(1, 1'b1, 3, 2'b11);
    set_in(4, 1'b1, 0, 2'b11);
    exp_ack(5'b10010, xs(xs(XB_IDLE, 3, 1), 0, 4));
    cyc();
    exp_xbar = xs(xs(XB_IDLE, 3, 1), 0, 4);
    probe("t5_dual_grant", 5'b10010, 5'b0, 5'b0);
    set_in(1, 1'b1, 3, 2'b01);
    set_in(4, 1'b1, 0, 2'b01);
    cyc();
    probe("t5_dual_active", 5'b0, 5'b10010, 5'b0);
    cyc();
    do_reset();
    set_in(1, 1'b1, 5, 2'b01);
    for (int k = 0; k < 3; k++) begin
      probe("t5_noroute_body", 5'b0, 5'b0, 5'b0);
      cyc();
    end
    set_in(1, 1'b1, 5, 2'b11);
    for (int k = 0; k < 3; k++) begin
      probe("t5_noroute_head", 5'b0, 5'b0, 5'b0);
      cyc();
    end

    // Test 6: asynchronous reset while output 3 is active with one credit left
    do_reset();
    set_in(2, 1'b1, 3, 2'b11);
    exp_ack(5'b00100, xs(XB_IDLE, 3, 2));
    cyc();
    exp_xbar = xs(XB_IDLE, 3, 2);
    set_in(2, 1'b1, 3, 2'b01);
    cyc();
    pop[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_out(3, 3'(4 - k));
      cyc();
      exp_cred = xs(exp_cred, 3, 3 - k);
    end
    pop[2] = 1'b0;
    probe("t6_active_cred1", 5'b0, 5'b00100, 5'b0);
    cyc();
    reset = 1'b0;
    #1;
    exp_xbar = XB_IDLE;
    exp_cred = CRED_ALL;
    probe("t6_async_reset", 5'b0, 5'b0, 5'b0);
    set_in(2, 1'b0, 0, 2'b00);
    cyc();
    reset = 1'b1;
    probe("t6_after_release", 5'b0, 5'b0, 5'b0);
    cyc();

    cyc();
    done = 1'b1;
  end

endmodule

// File: doc/sw_alloc_ctrl.md
Name: sw_alloc_ctrl

Overview:
- Switch allocator and crossbar sequencer for the 5-port mesh router.
- Each input port presents one routed request: its chosen output number, i.e. out_num from the route stage, plus the front flit type.
- Per output port, the block arbitrates round-robin among header requests and locks the output to the winner until that packet's tail passes (wormhole).
- Tracks downstream buffer credits per output, paces pops with st_go, and drives the crossbar selects.

Parameters:
- NPORT, 5, number of input and output ports.
- PIDX_W, 3, width of a port index. Value 7 means idle.
- CRED_MAX, 4, downstream buffer depth. Initial and maximum credits per output.
- CRED_W, 3, credit counter width. Must hold CRED_MAX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NPORT  input i has a valid flit at its buffer head.
- req_out  in  NPORT*PIDX_W  slice i is the target output for input i. Values >= NPORT mean no route.
- flit_type  in  NPORT*2  slice i is the head flit type of input i: 11 header, 01 body, 10 tail, 00 invalid.
- pop  in  NPORT  input i transfers its head flit this cycle.
- credit_ret  in  NPORT  pulse: output o's downstream freed one slot.
- st_ack  out  NPORT  one-cycle pulse: input i won its output.
- st_go  out  NPORT  input i may pop this cycle.
- xbar_sel  out  NPORT*PIDX_W  slice o is the input driving output o. 7 when idle.
- out_valid  out  NPORT  output o carries a flit this cycle.
- credits  out  NPORT*CRED_W  current credit count per output, for debug and verification.

Behaviour:
- Reset (asserted low, asynchronous) sets:
  - all outputs to IDLE; st_ack, st_go and out_valid to 0;
  - every xbar_sel slice to 7; every credit count to CRED_MAX;
  - every rr_ptr to 0.
  Reset mid-packet drops all locks immediately and does not wait for the tail.
- Per-output FSM has three states: IDLE, GRANT and ACTIVE. Transitions are registered.
- IDLE:
  - Eligible inputs satisfy all of: req[i]=1, req_out[i]=o, flit_type[i]=11, and input i owns no other output.
  - Winner is the first eligible input scanning i = rr_ptr[o], rr_ptr[o]+1, ... modulo NPORT.
  - With a winner, next state is GRANT and owner[o] is registered.
  - With no eligible input, the state stays IDLE.
- GRANT (exactly 1 cycle):
  - st_ack[owner]=1 and xbar_sel[o]=owner. st_go stays 0.
  - Next state is ACTIVE.
- ACTIVE:
  - xbar_sel[o]=owner. st_go[owner]=1 when credits[o]!=0 (combinational).
  - out_valid[o]=pop[owner] & st_go[owner], in the same cycle.
  - A pop while st_go=0 is ignored: no out_valid and no credit change.
- Release: a qualified pop in ACTIVE with flit_type[owner]=10 returns the output to IDLE on the next edge and sets rr_ptr[o]=(owner+1) mod NPORT.
  - A header or body seen while ACTIVE never releases.
  - The earliest re-grant of o is 2 cycles after the tail: IDLE evaluation, then GRANT.
- Latency: header at the head → st_ack 1 cycle later → st_go 2 cycles later, assuming credits are nonzero.
- Credits:
  - A qualified pop decrements credits[o]; credit_ret[o] increments it.
  - Both in the same cycle leave it unchanged.
  - An increment at CRED_MAX saturates and is ignored.
  - A decrement never occurs at 0, because st_go gates it.
  - Credits persist across packets.
- Independence: outputs allocate in parallel, so up to NPORT grants can happen in one cycle.
  - Since each input targets a single output, an input never receives two st_ack pulses in the same cycle.
- Requests with req_out >= NPORT (e.g. 5, no route) are never granted and do not advance rr_ptr.

Test Plan:
- Reset release, then input 2 sends a header to output 4 → cycle+1 st_ack[2]=1; cycle+2 st_go[2]=1, xbar_sel[4]=2. Two body pops then a tail pop → out_valid[4] pulses 3 times, credits[4] goes 4→1, and output 4 returns to IDLE with xbar_sel=7.
- Inputs 0, 1 and 3 all send headers to output 2 with rr_ptr=0 → grant order 0, 1, 3 across three 2-flit packets; after the last tail, rr_ptr[2]=4.
- Output 1 with CRED_MAX=4 and no credit_ret: owner pops 4 flits → st_go drops to 0 with credits=0, and a 5th pop is ignored. One credit_ret pulse → st_go=1 the next cycle.
- Simultaneous pop and credit_ret on output 0 at credits=2 → credits stays 2. A credit_ret at credits=4 → stays 4.
- Input 1 sends a header to output 3 and input 4 sends a header to output 0 in the same cycle → both st_ack pulse in the same cycle and both outputs reach ACTIVE together. Input 1 presenting a body with req_out=5 is never granted.
- Reset asserted while output 3 is ACTIVE with credits=1 → state, xbar_sel[3] and st_go drop immediately to IDLE, 7 and 0; after release, credits[3]=4.
